// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Holds one instruction for the core, retires it on instr_ready and steers the
// next fetch from PC+4 or the controller's redirect target.
// Build option: define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect
// targets in a sticky FAULT state. Without it, targets are force-aligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        fetch_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        retire;

    assign PCPlus4   = pc_q + 32'd4;
    assign PC        = pc_q;
    assign Instr     = instr_q;
    assign imem_addr = pc_q;
    assign retire    = (state == S_HOLD) && instr_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
    // FAULT is terminal until reset, so the state itself is the sticky flag.
    assign fetch_fault = (state == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

    // State, PC and held instruction; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
        end
    end

    // Next-state, next-PC and handshake outputs.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_q;
        instr_nxt      = instr_q;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        case (state)
            S_REQ: begin
                // State already reads REQ during reset; keep the bus quiet.
                imem_req_valid = !reset;
                if (imem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_nxt = imem_rsp_data;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (retire) begin
                    state_nxt = S_REQ;
                    if (PCSrc) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                        if (PCTarget[1:0] != 2'b00) state_nxt = S_FAULT;
                        else                        pc_nxt    = PCTarget;
`else
                        pc_nxt = PCTarget & 32'hFFFF_FFFC;
`endif
                    end else begin
                        pc_nxt = PCPlus4;
                    end
                end
            end
            default: begin
                // FAULT: no requests, nothing valid, wait for reset.
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with literal expectations, then random
// memory/core behaviour, all cross-checked every cycle by a transaction model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        fetch_fault;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .Instr(Instr), .PC(PC),
        .PCPlus4(PCPlus4), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .fetch_fault(fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: which fetch is outstanding, what the core holds,
    // and where the next fetch must go.
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = NOP;
    bit          m_busy  = 0;   // request accepted, response not yet seen
    bit          m_hold  = 0;   // an instruction is offered to the core
    bit          m_fault = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_instr = NOP; m_busy = 0; m_hold = 0; m_fault = 0;
        end
        chk("m_req_valid", {31'b0, imem_req_valid}, {31'b0, !reset && !m_busy && !m_hold && !m_fault});
        if (imem_req_valid) chk("m_imem_addr", imem_addr, m_pc);
        chk("m_instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
        chk("m_instr", Instr, m_instr);
        chk("m_pc", PC, m_pc);
        chk("m_pcplus4", PCPlus4, m_pc + 32'd4);
        chk("m_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        // Predict the effect of the upcoming rising edge.
        if (!reset && !m_fault) begin
            if (m_hold) begin
                if (instr_ready) begin
                    m_hold = 0;
                    if (!PCSrc) m_pc = m_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
                    else if (PCTarget % 4 != 0) m_fault = 1;
                    else m_pc = PCTarget;
`else
                    else m_pc = PCTarget - (PCTarget % 4);
`endif
                end
            end else if (m_busy) begin
                if (imem_rsp_valid) begin
                    m_instr = imem_rsp_data; m_busy = 0; m_hold = 1;
                end
            end else if (imem_req_ready) begin
                m_busy = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starting in the request phase: expect a fetch of addr, serve it in one cycle.
    task automatic fetch_chk(input logic [31:0] addr, input logic [31:0] data);
        chk("dir_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("dir_addr", imem_addr, addr);
        imem_req_ready = 1'b1;
        step();
        chk("dir_wait_noreq", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = data;
        step();
        imem_rsp_valid = 1'b0;
        chk("dir_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("dir_instr", Instr, data);
        chk("dir_pc", PC, addr);
    endtask

    task automatic retire_with(input logic src, input logic [31:0] tgt);
        instr_ready = 1'b1; PCSrc = src; PCTarget = tgt;
        step();
        instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = $urandom;
    endtask

    initial begin
        reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
        repeat (3) step();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", Instr, NOP);
        chk("rst_pc", PC, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // First fetch after release, valid on the third cycle.
        reset = 1'b0;
        #1;
        fetch_chk(32'h0, 32'h0050_0093);
        chk("first_pcplus4", PCPlus4, 32'h4);

        // Sequential retires, then a taken redirect from PC=8.
        retire_with(1'b0, 32'h0);
        fetch_chk(32'h4, 32'h1111_1111);
        retire_with(1'b0, 32'h0);
        fetch_chk(32'h8, 32'h2222_2222);
        retire_with(1'b1, 32'h40);
        fetch_chk(32'h40, 32'h3333_3333);

        // Memory stalls the request 3 cycles, then answers 2 cycles late.
        retire_with(1'b0, 32'h0);
        imem_req_ready = 1'b0;
        #1;
        repeat (3) begin
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_addr, 32'h44);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        repeat (2) begin
            chk("late_no_dup_req", {31'b0, imem_req_valid}, 32'd0);
            chk("late_not_valid", {31'b0, instr_valid}, 32'd0);
            step();
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4444_4444;
        step();
        imem_rsp_valid = 1'b0;
        chk("late_instr", Instr, 32'h4444_4444);
        chk("late_pc", PC, 32'h44);

        // Reset during WAIT; stale response arrives in the first REQ cycle.
        retire_with(1'b0, 32'h0);
        step();
        reset = 1'b1;
        step();
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        #1;
        chk("midrst_req_addr", imem_addr, 32'h0);
        chk("midrst_req_again", {31'b0, imem_req_valid}, 32'd1);
        step();
        imem_rsp_valid = 1'b0;
        chk("stale_dropped", Instr, NOP);
        chk("stale_not_valid", {31'b0, instr_valid}, 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_5555;
        step();
        imem_rsp_valid = 1'b0;
        chk("fresh_instr", Instr, 32'h5555_5555);
        chk("fresh_pc", PC, 32'h0);

        // Misaligned redirect target.
        retire_with(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
        repeat (3) begin
            chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
            chk("mis_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("mis_pc_kept", PC, 32'h0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
`else
        fetch_chk(32'h40, 32'h6666_6666);
        chk("mis_no_fault", {31'b0, fetch_fault}, 32'd0);
`endif

        // Random memory timing, core backpressure, redirects, resets.
        for (int i = 0; i < 4000; i++) begin
            step();
            reset          = ($urandom_range(0, 199) == 0);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            imem_rsp_valid = ($urandom_range(0, 9) < 5);
            imem_rsp_data  = $urandom;
            instr_ready    = ($urandom_range(0, 9) < 5);
            PCSrc          = ($urandom_range(0, 9) < 3);
            PCTarget       = $urandom;
            if ($urandom_range(0, 19) != 0) PCTarget[1:0] = 2'b00;
        end
        reset = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req_valid  output  1  instruction-memory request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port imem_addr  output  32  request address, equals PC.
REQ-007 SHALL have port imem_rsp_valid  input  1  read data valid.
REQ-008 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL have port Instr  output  32  held instruction to decode/controller.
REQ-010 SHALL have port PC  output  32  address of Instr.
REQ-011 SHALL have port PCPlus4  output  32  PC + 4, modulo 2^32.
REQ-012 SHALL have port instr_valid  output  1  Instr/PC are valid for execution.
REQ-013 SHALL have port instr_ready  input  1  core executes held instruction this cycle.
REQ-014 SHALL have port PCSrc  input  1  controller redirect (branch taken or jump), sampled only on retire.
REQ-015 SHALL have port PCTarget  input  32  redirect target address.
REQ-016 SHALL have port fetch_fault  output  1  sticky misaligned-target flag.

Function
REQ-017 SHALL implement FSM states REQ, WAIT, HOLD, FAULT; one outstanding request maximum.
REQ-018 In REQ: imem_req_valid=1, imem_addr=PC; on imem_req_ready go to WAIT, else stay.
REQ-019 In WAIT: imem_req_valid=0; on imem_rsp_valid capture imem_rsp_data into Instr, go to HOLD.
REQ-020 In HOLD: instr_valid=1; Instr/PC stable until retire.
REQ-021 Retire = HOLD & instr_ready; on retire PC <= PCSrc ? PCTarget : PCPlus4, go to REQ.
REQ-022 instr_valid SHALL be 0 in REQ, WAIT, FAULT; PCSrc/PCTarget ignored when not retiring.
REQ-023 imem_rsp_valid outside WAIT SHALL be ignored (no state or Instr change).
REQ-024 Minimum fetch-to-valid latency: request accepted cycle N, response cycle N+1, instr_valid cycle N+2.
REQ-025 PCPlus4 SHALL be combinational PC+4; wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-026 FAULT state: no requests, instr_valid=0, fetch_fault=1, exited only by reset.

Reset
REQ-027 On reset assertion, asynchronously: PC=RESET_PC, state=REQ, Instr=32'h0000_0013 (NOP), instr_valid=0, fetch_fault=0.
REQ-028 Reset mid-WAIT SHALL abandon the in-flight request; its late response is dropped per REQ-023.
REQ-029 imem_req_valid SHALL be 0 while reset is asserted; first request in first cycle after deassertion.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN SHALL select misalignment handling.
REQ-031 Defined: retire with PCSrc=1 and PCTarget[1:0]!=0 SHALL leave PC unchanged, set fetch_fault, enter FAULT.
REQ-032 Undefined: PC <= {PCTarget[31:2],2'b00}; FAULT state unreachable; fetch_fault tied 0.

Verification
REQ-033 Reset with RESET_PC=0, imem_req_ready=1, 1-cycle response 32'h00500093 -> imem_addr=0, instr_valid on 3rd cycle after reset release, Instr=32'h00500093, PC=0, PCPlus4=4.
REQ-034 Sequential retire, PCSrc=0, instr_ready=1 each HOLD -> imem_addr sequence 0,4,8,12.
REQ-035 Retire at PC=8 with PCSrc=1, PCTarget=32'h40 -> next imem_addr=32'h40, PC=32'h40.
REQ-036 imem_req_ready low 3 cycles, then response delayed 2 cycles -> imem_addr held stable, instr_valid only after response, no duplicate request.
REQ-037 Reset asserted in WAIT, response arrives during first REQ cycle after release -> response ignored, new request to RESET_PC, Instr stays NOP until new response.
REQ-038 With FETCH_MISALIGN_CHECK_EN, retire PCSrc=1, PCTarget=32'h42 -> fetch_fault=1, imem_req_valid=0 thereafter; without macro -> next imem_addr=32'h40, fetch_fault=0.
